// File: rtl/scan_chain_ctrl.sv
// Serial scan controller: shifts an address then a data word into one of
// NUM_CHAINS configuration registers, with simultaneous readback on scan_out.
module scan_chain_ctrl #(
  parameter int unsigned                         ADDR_W      = 12,
  parameter int unsigned                         DATA_W      = 160,
  parameter int unsigned                         NUM_CHAINS  = 5,
  parameter logic [NUM_CHAINS*ADDR_W-1:0]        CHAIN_ADDRS = {12'd2, 12'd5, 12'd1, 12'd3, 12'd4},
  parameter logic [NUM_CHAINS*DATA_W-1:0]        RESET_VALS  = '0,
  parameter logic [NUM_CHAINS-1:0]               RDBK_EXT    = '0
) (
  input  logic                         scan_clk,
  input  logic                         reset,
  input  logic                         scan_en,
  input  logic                         scan_in,
  output logic                         scan_out,
  input  logic [NUM_CHAINS*DATA_W-1:0] chain_rd_data,
  output logic [NUM_CHAINS*DATA_W-1:0] chain_out,
  output logic [NUM_CHAINS-1:0]        chain_update,
  output logic                         txn_done,
  output logic [1:0]                   txn_status
);

  localparam int unsigned AC_W  = $clog2(ADDR_W + 1);
  localparam int unsigned DC_W  = $clog2(DATA_W + 2);
  localparam int unsigned IDX_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_MISS  = 2'b01;
  localparam logic [1:0] ST_LEN   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_reg;
  logic [AC_W-1:0]    addr_cnt;
  logic [DC_W-1:0]    data_cnt;
  logic [DATA_W-1:0]  sh;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  logic [ADDR_W-1:0]  addr_nxt_c;
  logic [AC_W-1:0]    addr_cnt_nxt_c;
  logic               addr_last_c;
  logic [DATA_W-1:0]  sh_nxt_c;
  logic               hit_c;
  logic [IDX_W-1:0]   hit_idx_c;
  logic [DATA_W-1:0]  rdbk_c;

  assign scan_out = sh[DATA_W-1];

  // Shift helpers; truncating the concatenation keeps the 1-bit-wide cases legal.
  always_comb begin
    addr_nxt_c     = ADDR_W'({addr_reg, scan_in});
    sh_nxt_c       = DATA_W'({sh, scan_in});
    addr_cnt_nxt_c = (state == IDLE) ? AC_W'(1) : addr_cnt + AC_W'(1);
    addr_last_c    = (addr_cnt_nxt_c == AC_W'(ADDR_W));
  end

  // Address decode on the incoming address; lowest matching chain wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    rdbk_c    = '0;
    for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
      if (!hit_c && (addr_nxt_c == CHAIN_ADDRS[i*ADDR_W +: ADDR_W])) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
        rdbk_c    = RDBK_EXT[i] ? chain_rd_data[i*DATA_W +: DATA_W]
                                : chain_out[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_reg     <= '0;
      addr_cnt     <= '0;
      data_cnt     <= '0;
      sh           <= '0;
      hit          <= 1'b0;
      hit_idx      <= '0;
      chain_out    <= RESET_VALS;
      chain_update <= '0;
      txn_done     <= 1'b0;
      txn_status   <= ST_OK;
    end else begin
      chain_update <= '0;
      txn_done     <= 1'b0;
      case (state)
        IDLE, ADDR: begin
          if (scan_en) begin
            addr_reg <= addr_nxt_c;
            addr_cnt <= addr_cnt_nxt_c;
            if (addr_last_c) begin
              // Preload readback so its MSB is on scan_out before the first data edge.
              hit      <= hit_c;
              hit_idx  <= hit_idx_c;
              sh       <= rdbk_c;
              data_cnt <= '0;
              state    <= DATA;
            end else begin
              state <= ADDR;
            end
          end else if (state == ADDR) begin
            txn_done   <= 1'b1;
            txn_status <= ST_ABORT;
            addr_cnt   <= '0;
            state      <= IDLE;
          end
        end
        DATA: begin
          if (scan_en) begin
            sh <= sh_nxt_c;
            if (data_cnt != DC_W'(DATA_W + 1)) begin
              data_cnt <= data_cnt + DC_W'(1);
            end
          end else begin
            if (hit && (data_cnt == DC_W'(DATA_W))) begin
              txn_status <= ST_OK;
              for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
                if (hit_idx == IDX_W'(i)) begin
                  chain_out[i*DATA_W +: DATA_W] <= sh;
                  chain_update[i]               <= 1'b1;
                end
              end
            end else if (!hit) begin
              txn_status <= ST_MISS;
            end else begin
              txn_status <= ST_LEN;
            end
            txn_done <= 1'b1;
            sh       <= '0;
            addr_cnt <= '0;
            data_cnt <= '0;
            hit      <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: directed vector table, hand-written corner
// sequences, and randomized transactions checked against a register-file model.
module tb_scan_chain_ctrl;

  localparam logic [1:0] RDBK = 2'b10;

  logic        scan_clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic        scan_in;
  logic        scan_out;
  logic [15:0] rd_data;
  logic [15:0] chain_out;
  logic [1:0]  chain_update;
  logic        txn_done;
  logic [1:0]  txn_status;

  scan_chain_ctrl #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .NUM_CHAINS  (2),
    .CHAIN_ADDRS ({4'h5, 4'h3}),
    .RESET_VALS  ({8'h0F, 8'h00}),
    .RDBK_EXT    (RDBK)
  ) dut (
    .scan_clk      (scan_clk),
    .reset         (reset),
    .scan_en       (scan_en),
    .scan_in       (scan_in),
    .scan_out      (scan_out),
    .chain_rd_data (rd_data),
    .chain_out     (chain_out),
    .chain_update  (chain_update),
    .txn_done      (txn_done),
    .txn_status    (txn_status)
  );

  always #5 scan_clk = ~scan_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  int upd_seen  = 0;
  int exp_done  = 0;
  int exp_upd   = 0;

  // Model: the two chain registers and their addresses.
  logic [7:0] model_regs [2];
  logic [3:0] model_addrs [2];

  // Each strobe is one cycle wide, so it is seen at exactly one falling edge.
  always @(negedge scan_clk) begin
    if (txn_done === 1'b1) done_seen++;
    if (chain_update !== 2'b00) upd_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lookup(input logic [3:0] a);
    for (int i = 0; i < 2; i++) if (model_addrs[i] == a) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    model_regs[0] = 8'h00;
    model_regs[1] = 8'h0F;
  endfunction

  // One transaction: n_addr address bits (abort if < 4), then nd data bits MSB first.
  task automatic do_txn(input logic [3:0] addr, input int n_addr, input logic [15:0] data,
                        input int nd, input bit idle_after);
    int         idx;
    logic [7:0] rb;
    logic       exp_bit;
    logic [1:0] es;
    logic [1:0] eu;
    idx = lookup(addr);
    rb  = 8'h00;
    if (idx >= 0) rb = RDBK[idx] ? rd_data[idx*8 +: 8] : model_regs[idx];
    for (int a = 0; a < n_addr; a++) begin
      @(negedge scan_clk);
      scan_en = 1'b1;
      scan_in = addr[3-a];
    end
    if (n_addr == 4) begin
      for (int k = 0; k < nd; k++) begin
        @(negedge scan_clk);
        exp_bit = (k < 8) ? rb[7-k] : data[nd-1-(k-8)];
        check($sformatf("scan_out bit%0d", k), 32'(scan_out), 32'(exp_bit));
        scan_in = data[nd-1-k];
      end
    end
    @(negedge scan_clk);
    scan_en = 1'b0;
    scan_in = 1'b0;
    eu = 2'b00;
    if (n_addr < 4)    es = 2'b11;
    else if (idx < 0)  es = 2'b01;
    else if (nd != 8)  es = 2'b10;
    else begin
      es = 2'b00;
      model_regs[idx] = data[7:0];
      eu = 2'(1 << idx);
    end
    exp_done++;
    if (eu != 2'b00) exp_upd++;
    @(posedge scan_clk);
    #1;
    check("txn_done", 32'(txn_done), 32'd1);
    check("txn_status", 32'(txn_status), 32'(es));
    check("chain_update", 32'(chain_update), 32'(eu));
    check("chain_out", 32'(chain_out), 32'({model_regs[1], model_regs[0]}));
    check("scan_out_cleared", 32'(scan_out), 32'd0);
    if (idle_after) begin
      @(posedge scan_clk);
      #1;
      check("txn_done_pulse", 32'(txn_done), 32'd0);
      check("chain_update_pulse", 32'(chain_update), 32'd0);
      check("txn_status_held", 32'(txn_status), 32'(es));
    end
  endtask

  typedef struct {
    logic [3:0]  addr;
    int          n_addr;
    logic [15:0] data;
    int          nd;
    logic [15:0] rd;
    logic [1:0]  st;
    logic [15:0] co;
  } vec_t;

  vec_t vecs [7];

  initial begin
    model_addrs[0] = 4'h3;
    model_addrs[1] = 4'h5;
    model_reset();

    vecs[0] = '{4'h3, 4, 16'h00A5, 8, 16'hC300, 2'b00, 16'h0FA5};
    vecs[1] = '{4'h3, 4, 16'h003C, 8, 16'hC300, 2'b00, 16'h0F3C};
    vecs[2] = '{4'h5, 4, 16'h0011, 8, 16'hC300, 2'b00, 16'h113C};
    vecs[3] = '{4'h7, 4, 16'h00FF, 8, 16'hC300, 2'b01, 16'h113C};
    vecs[4] = '{4'h3, 4, 16'h0055, 7, 16'hC300, 2'b10, 16'h113C};
    vecs[5] = '{4'h3, 4, 16'h0155, 9, 16'hC300, 2'b10, 16'h113C};
    vecs[6] = '{4'h3, 2, 16'h0000, 0, 16'hC300, 2'b11, 16'h113C};

    reset   = 1'b1;
    scan_en = 1'b0;
    scan_in = 1'b0;
    rd_data = 16'h0000;
    repeat (2) @(negedge scan_clk);
    check("rst_chain_out", 32'(chain_out), 32'h0F00);
    check("rst_scan_out", 32'(scan_out), 32'd0);
    check("rst_status", 32'(txn_status), 32'd0);
    check("rst_done", 32'(txn_done), 32'd0);
    check("rst_update", 32'(chain_update), 32'd0);
    reset = 1'b0;
    @(negedge scan_clk);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      rd_data = vecs[i].rd;
      do_txn(vecs[i].addr, vecs[i].n_addr, vecs[i].data, vecs[i].nd, 1'b1);
      check($sformatf("vec%0d_status", i), 32'(txn_status), 32'(vecs[i].st));
      check($sformatf("vec%0d_chain_out", i), 32'(chain_out), 32'(vecs[i].co));
    end
    check("done_count_table", 32'(done_seen), 32'(exp_done));

    // Back-to-back commits with only the scan_en-low edge between them
    do_txn(4'h3, 4, 16'h005A, 8, 1'b0);
    do_txn(4'h5, 4, 16'h0096, 8, 1'b1);
    check("b2b_chain_out", 32'(chain_out), 32'h965A);
    check("b2b_done_count", 32'(done_seen), 32'(exp_done));
    check("b2b_upd_count", 32'(upd_seen), 32'(exp_upd));

    // Reset asserted mid data phase: abort without txn_done
    for (int a = 0; a < 4; a++) begin
      @(negedge scan_clk);
      scan_en = 1'b1;
      scan_in = a[0];
      if (a == 2) scan_in = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge scan_clk);
      scan_in = k[0];
    end
    @(negedge scan_clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_chain_out", 32'(chain_out), 32'h0F00);
    check("midrst_scan_out", 32'(scan_out), 32'd0);
    check("midrst_status", 32'(txn_status), 32'd0);
    check("midrst_done", 32'(txn_done), 32'd0);
    check("midrst_update", 32'(chain_update), 32'd0);
    model_reset();
    scan_en = 1'b0;
    scan_in = 1'b0;
    repeat (2) @(negedge scan_clk);
    reset = 1'b0;
    check("midrst_no_done", 32'(done_seen), 32'(exp_done));
    @(negedge scan_clk);

    // Randomized transactions against the model
    for (int t = 0; t < 60; t++) begin
      logic [3:0]  ra;
      int          rn;
      int          rna;
      int          sel;
      rd_data = 16'($urandom);
      sel = $urandom_range(0, 3);
      ra  = (sel == 0) ? 4'h3 : (sel == 1) ? 4'h5 : 4'($urandom);
      sel = $urandom_range(0, 5);
      rn  = (sel <= 3) ? 8 : (sel == 4) ? $urandom_range(0, 7) : $urandom_range(9, 12);
      rna = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
      do_txn(ra, rna, 16'($urandom), rn, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge scan_clk);
    check("final_done_count", 32'(done_seen), 32'(exp_done));
    check("final_upd_count", 32'(upd_seen), 32'(exp_upd));
    check("final_chain_out", 32'(chain_out), 32'({model_regs[1], model_regs[0]}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
